uart_dbg_responder: RTL

UART_DBG_RESPONDER -- requirements
Module: uart_dbg_responder

---
 rtl/uart_dbg_pkg.sv | 28 ++
 rtl/uart_dbg_txser.sv | 37 +++
 rtl/uart_dbg_responder.sv | 129 ++++++++++++
 3 files changed

// File: rtl/uart_dbg_pkg.sv
// Shared definitions for the UART debug responder: command codes,
// single-byte reply codes and the parser FSM state encoding.
package uart_dbg_pkg;

  localparam logic [7:0] CMD_PC   = 8'h50;  // 'P'
  localparam logic [7:0] CMD_REG  = 8'h52;  // 'R'
  localparam logic [7:0] CMD_HALT = 8'h48;  // 'H'
  localparam logic [7:0] CMD_GO   = 8'h47;  // 'G'

  localparam logic [7:0] RPL_OK   = 8'h4B;  // 'K'
  localparam logic [7:0] RPL_ERR  = 8'h3F;  // '?'

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARG   = 3'd1,
    ST_FETCH = 3'd2,
    ST_LOAD  = 3'd3,
    ST_SEND  = 3'd4,
    ST_GAP   = 3'd5
  } state_t;

  // Places a single reply byte in the top byte of the shift word so the
  // serializer sends it first.
  function automatic logic [31:0] byte_word(input logic [7:0] b);
    return {b, 24'h000000};
  endfunction

endpackage

// File: rtl/uart_dbg_txser.sv
// Reply serializer: holds the captured reply word and its byte count,
// and hands bytes to the UART transmitter MSB first.
module uart_dbg_txser (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_word,
  input  logic [2:0]  load_count,
  input  logic        send_en,
  input  logic        tx_busy,
  output logic [7:0]  tx_data,
  output logic        tx_we,
  output logic [2:0]  count
);

  logic [31:0] shift_q;

  // The strobe is only offered while the parser sits in SEND and the
  // transmitter is free; reset suppresses it outright.
  assign tx_we   = send_en && !tx_busy && !rst;
  assign tx_data = shift_q[31:24];

  // Capture the reply once, then shift one byte out per accepted strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= 32'h0;
      count   <= 3'd0;
    end else if (load) begin
      shift_q <= load_word;
      count   <= load_count;
    end else if (tx_we) begin
      shift_q <= {shift_q[23:0], 8'h00};
      count   <= count - 3'd1;
    end
  end

endmodule

// File: rtl/uart_dbg_responder.sv
// UART debug responder: parses single-byte debug commands from the UART
// receiver and answers with the PC, a register probe word or a status byte.
module uart_dbg_responder
  import uart_dbg_pkg::*;
#(
  parameter logic [31:0] TIMEOUT_CYC = 32'd10_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_re,
  output logic [7:0]  tx_data,
  output logic        tx_we,
  input  logic        tx_busy,
  input  logic [31:0] pc_in,
  output logic [4:0]  dbg_addr,
  input  logic [31:0] dbg_rdata,
  output logic        cpu_halt
);

  state_t      state_q, state_d;
  logic [31:0] timer_q;
  logic        arg_expired;
  logic        load;
  logic [31:0] load_word;
  logic [2:0]  load_count;
  logic        send_en;
  logic [2:0]  tx_count;

  assign arg_expired = (timer_q >= (TIMEOUT_CYC - 32'd1));

  uart_dbg_txser u_txser (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .load_word  (load_word),
    .load_count (load_count),
    .send_en    (send_en),
    .tx_busy    (tx_busy),
    .tx_data    (tx_data),
    .tx_we      (tx_we),
    .count      (tx_count)
  );

  // Next-state logic: decode commands in IDLE, take the probe index in ARG,
  // wait out the probe read latency, then pace bytes through SEND/GAP.
  always_comb begin
    state_d    = state_q;
    rx_re      = 1'b0;
    load       = 1'b0;
    load_word  = 32'h0;
    load_count = 3'd0;
    send_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rx_valid) begin
          rx_re = 1'b1;
          if (rx_data == CMD_REG) begin
            state_d = ST_ARG;
          end else begin
            load    = 1'b1;
            state_d = ST_SEND;
            if (rx_data == CMD_PC) begin
              load_word  = pc_in;
              load_count = 3'd4;
            end else if (rx_data == CMD_HALT || rx_data == CMD_GO) begin
              load_word  = byte_word(RPL_OK);
              load_count = 3'd1;
            end else begin
              load_word  = byte_word(RPL_ERR);
              load_count = 3'd1;
            end
          end
        end
      end
      ST_ARG: begin
        if (rx_valid) begin
          rx_re   = 1'b1;
          state_d = ST_FETCH;
        end else if (arg_expired) begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: state_d = ST_LOAD;
      ST_LOAD: begin
        load       = 1'b1;
        load_word  = dbg_rdata;
        load_count = 3'd4;
        state_d    = ST_SEND;
      end
      ST_SEND: begin
        send_en = 1'b1;
        if (!tx_busy) state_d = ST_GAP;
      end
      ST_GAP: state_d = (tx_count != 3'd0) ? ST_SEND : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (rst) rx_re = 1'b0;
  end

  // State register plus the argument timeout counter, which only runs
  // while ARG is waiting and restarts from zero on every other cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      timer_q <= 32'h0;
    end else begin
      state_q <= state_d;
      timer_q <= (state_q == ST_ARG && !rx_valid) ? timer_q + 32'd1 : 32'h0;
    end
  end

  // Debug-side registers: the probe index is latched from the 'R' argument
  // and the halt flag follows 'H'/'G' on the edge ending their consume cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      dbg_addr <= 5'd0;
      cpu_halt <= 1'b0;
    end else begin
      if (rx_re && state_q == ST_ARG) dbg_addr <= rx_data[4:0];
      if (rx_re && state_q == ST_IDLE) begin
        if (rx_data == CMD_HALT)    cpu_halt <= 1'b1;
        else if (rx_data == CMD_GO) cpu_halt <= 1'b0;
      end
    end
  end

endmodule
